// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the push-button conditioning path.
package debounce_sync_pkg;

  // state | meaning
  // ESTABLE_BAJO   | accepted level is 0, waiting for q to rise
  // VALIDANDO_ALTO | q went high, counting stable samples before accepting 1
  // ESTABLE_ALTO   | accepted level is 1, waiting for q to fall
  // VALIDANDO_BAJO | q went low, counting stable samples before accepting 0
  typedef enum logic [1:0] {
    ESTABLE_BAJO   = 2'd0,
    VALIDANDO_ALTO = 2'd1,
    ESTABLE_ALTO   = 2'd2,
    VALIDANDO_BAJO = 2'd3
  } debounce_state_t;

  // 10 ms of stable input at a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;

endpackage

// File: rtl/debounce_sync_sincronizador.sv
// Multi-flop synchronizer for asynchronous single-bit inputs (buttons, switches).
module sincronizador
  import debounce_sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; only the last flop is used downstream.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Raw button pin -> synchronizer -> counter-based debouncer -> clean level
// plus a one-cycle press pulse.
//
// state          | meaning
// ESTABLE_BAJO   | nivel_o = 0 accepted, idle
// VALIDANDO_ALTO | q high, counting toward accepting a press
// ESTABLE_ALTO   | nivel_o = 1 accepted, idle
// VALIDANDO_BAJO | q low, counting toward accepting a release
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int SYNC_STAGES   = 2,
  parameter bit INVERT        = 1'b0
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic boton_i,
  output logic nivel_o,
  output logic pulsacion_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic            b;
  logic            q;
  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  // Polarity is normalised before synchronizing so the FSM always sees 1 = pressed.
  assign b = boton_i ^ INVERT;

  sincronizador #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clck_i(clck_i),
    .rst_i (rst_i),
    .d_i   (b),
    .q_o   (q)
  );

  // Debounce FSM with registered level and press pulse; a flip of q during
  // validation, even on the last count, falls back to the stable state.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ESTABLE_BAJO;
      cnt         <= '0;
      nivel_o     <= 1'b0;
      pulsacion_o <= 1'b0;
    end else begin
      pulsacion_o <= 1'b0;
      case (state)
        ESTABLE_BAJO: begin
          if (q) begin
            state <= VALIDANDO_ALTO;
            cnt   <= '0;
          end
        end
        VALIDANDO_ALTO: begin
          if (!q) begin
            state <= ESTABLE_BAJO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ESTABLE_ALTO;
            nivel_o     <= 1'b1;
            pulsacion_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ESTABLE_ALTO: begin
          if (!q) begin
            state <= VALIDANDO_BAJO;
            cnt   <= '0;
          end
        end
        VALIDANDO_BAJO: begin
          if (q) begin
            state <= ESTABLE_ALTO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ESTABLE_BAJO;
            nivel_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ESTABLE_BAJO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Upstream conditioning stage for the push-button peripheral path: raw asynchronous button pin -> synchronizer -> counter-based debouncer -> clean level.
- Its nivel_o drives the boton_i input of the level-to-pulse converter directly. That converter's boton_i has no other conditioning, so every glitch or metastable sample must be removed here.
- Also provides an optional one-cycle press pulse for consumers that do not need release detection.

Parameters:
- STABLE_CYCLES, 1000000, consecutive synchronized samples (minus one) the input must hold before a change is accepted; 10 ms at 100 MHz; legal range >= 1.
- SYNC_STAGES, 2, flip-flops in the synchronizer chain; legal range >= 2.
- INVERT, 0, 1 = raw button is active-low; inverted before the synchronizer.

Ports:
- clck_i  in  1  system clock, rising-edge.
- rst_i  in  1  asynchronous reset, active-low.
- boton_i  in  1  raw button pin, asynchronous to clck_i, bouncing.
- nivel_o  out  1  debounced, synchronized button level; registered.
- pulsacion_o  out  1  single-cycle high on each accepted 0->1 transition of nivel_o; registered.

Behaviour:
- Reset (rst_i=0, asynchronous, effective immediately, including mid-validation):
  - sync chain = 0, FSM = ESTABLE_BAJO, counter = 0.
  - nivel_o = 0, pulsacion_o = 0.
- After rst_i deasserts, operation starts on the next rising edge.
- Synchronizer:
  - b = boton_i XOR INVERT, shifted through SYNC_STAGES flops.
  - The last flop output is q.
  - Only q is seen by the FSM.
- Counter:
  - Width = $clog2(STABLE_CYCLES+1).
  - Never exceeds STABLE_CYCLES-1; no wrap.
- FSM states: ESTABLE_BAJO, VALIDANDO_ALTO, ESTABLE_ALTO, VALIDANDO_BAJO.
- ESTABLE_BAJO:
  - q=1 -> VALIDANDO_ALTO, cnt <= 0.
  - Otherwise hold.
- VALIDANDO_ALTO:
  - q=0 -> ESTABLE_BAJO, cnt <= 0 (bounce rejected; nivel_o unchanged).
  - q=1 and cnt == STABLE_CYCLES-1 -> ESTABLE_ALTO, nivel_o <= 1, pulsacion_o <= 1.
  - Otherwise cnt <= cnt+1.
- ESTABLE_ALTO:
  - q=0 -> VALIDANDO_BAJO, cnt <= 0.
  - Otherwise hold.
- VALIDANDO_BAJO:
  - q=1 -> ESTABLE_ALTO, cnt <= 0.
  - q=0 and cnt == STABLE_CYCLES-1 -> ESTABLE_BAJO, nivel_o <= 0.
  - Otherwise cnt <= cnt+1.
- pulsacion_o:
  - Defaults to 0 every cycle; high for exactly one cycle, same cycle nivel_o first reads 1.
  - Never asserted on release.
- Latency:
  - Count edge 1 as the first rising edge that samples b=1.
  - nivel_o reads 1 after edge SYNC_STAGES+STABLE_CYCLES+1.
  - Release is symmetric.
- Acceptance threshold:
  - b must be stable for >= STABLE_CYCLES+1 consecutive edges to be accepted.
  - Pulses of <= STABLE_CYCLES edges are rejected with no output activity.
- Boundary conditions:
  - Bounce at the final count edge (cnt == STABLE_CYCLES-1 but q flips): returns to the stable state; no output change.
  - STABLE_CYCLES=1: a change is accepted after q holds for 2 edges.
  - No combinational path from boton_i to any output.

Decomposition:
- Shared peripherals package holds:
  - typedef enum logic [1:0] debounce_state_t {ESTABLE_BAJO, VALIDANDO_ALTO, ESTABLE_ALTO, VALIDANDO_BAJO};
  - localparam DEBOUNCE_10MS_100MHZ = 1000000.
- Sub-module: sincronizador (parameter STAGES; ports clck_i, rst_i, d_i, q_o).
  - Reset value 0.
  - Reusable for the switch inputs.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2, INVERT=0 unless noted):
- Clean press: boton_i 0->1, held 20 cycles -> nivel_o rises after edge 7 counting the first sampling edge; pulsacion_o high exactly 1 cycle, same cycle.
- Bounce rejection: boton_i high 4 cycles, low 1, high 3, low -> nivel_o stays 0, pulsacion_o never asserts.
- Minimum accept: boton_i high exactly 5 cycles then low -> nivel_o rises once. It falls 7 edges after the first low sample; one pulsacion_o only.
- Release bounce: from nivel_o=1, boton_i low 3 cycles, high 1, low 20 -> no glitch on nivel_o. nivel_o falls 7 edges after the final falling sample; no pulse on release.
- Async reset mid-validation: assert rst_i=0 between clock edges while in VALIDANDO_ALTO with cnt=2 -> nivel_o=0 and pulsacion_o=0 immediately without a clock edge. After release with boton_i held high, the full 7-edge latency restarts.
- INVERT=1: boton_i held 1 -> nivel_o=0. boton_i 1->0 held 10 cycles -> nivel_o rises after edge 7 with one pulsacion_o.
